// File: rtl/de_pkg.sv
// Shared widths and types for the decode stage and its per-register scoreboard counters.
package de_pkg;
  localparam int REGNO_W = 5;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef logic [CNT_W-1:0] sb_cnt_t;
endpackage

// File: rtl/de_sb_counter.sv
// Saturating up/down in-flight write counter for one architectural register.
// Simultaneous inc and dec hold the count; a dec at zero holds zero and pulses underflow.
module de_sb_counter
  import de_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero,
  output logic             max,
  output logic             underflow
);

  assign zero      = (cnt == '0);
  assign max       = (cnt == CNT_W'(CNT_MAX));
  assign underflow = dec & zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc && !dec && !max) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc && !zero) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/de_scoreboard_stage.sv
// Decode/issue stage: regfile, per-register pending-write counters and a 1-cycle valid/ready latch.
// Optional same-cycle WB operand bypass is enabled by defining DE_WB_BYPASS_EN.
module de_scoreboard_stage
  import de_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int PAYLOAD_W = 96
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fe_valid,
  output logic                 fe_ready,
  input  logic [REGNO_W-1:0]   fe_rs1,
  input  logic [REGNO_W-1:0]   fe_rs2,
  input  logic                 fe_rs1_rd,
  input  logic                 fe_rs2_rd,
  input  logic [REGNO_W-1:0]   fe_rd,
  input  logic                 fe_wr_reg,
  input  logic [PAYLOAD_W-1:0] fe_payload,
  output logic                 de_valid,
  input  logic                 de_ready,
  output logic [XLEN-1:0]      de_rs1_val,
  output logic [XLEN-1:0]      de_rs2_val,
  output logic [REGNO_W-1:0]   de_rd,
  output logic                 de_wr_reg,
  output logic [PAYLOAD_W-1:0] de_payload,
  input  logic                 wb_valid,
  input  logic [REGNO_W-1:0]   wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 flush,
  output logic                 busy,
  output logic                 sb_err
);

  logic [XLEN-1:0]        regs [NREGS];
  sb_cnt_t [NREGS-1:0]    cnt_arr;
  logic [NREGS-1:0]       zero_vec, max_vec, uf_vec;
  logic                   fe_fire, de_fire;
  logic                   hit1, hit2, hit_rd;
  logic [CNT_W:0]         pend1, pend2, pend_rd;
  logic                   byp1, byp2, src_haz1, src_haz2, waw_haz;
  logic [XLEN-1:0]        rs1_op, rs2_op;

  // Pending count includes a writer sitting in the output latch that has not yet been counted.
  function automatic logic [CNT_W:0] pend_of(input sb_cnt_t c, input logic hit);
    return {1'b0, c} + {{CNT_W{1'b0}}, hit};
  endfunction

  assign cnt_arr[0]  = '0;
  assign zero_vec[0] = 1'b1;
  assign max_vec[0]  = 1'b0;
  assign uf_vec[0]   = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_cnt
    logic inc_r, dec_r;
    assign inc_r = de_fire & de_wr_reg & (de_rd == REGNO_W'(r));
    assign dec_r = wb_valid & (wb_rd == REGNO_W'(r));
    de_sb_counter u_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc       (inc_r),
      .dec       (dec_r),
      .cnt       (cnt_arr[r]),
      .zero      (zero_vec[r]),
      .max       (max_vec[r]),
      .underflow (uf_vec[r])
    );
  end

  assign hit1   = de_valid & de_wr_reg & (de_rd == fe_rs1) & (fe_rs1 != '0);
  assign hit2   = de_valid & de_wr_reg & (de_rd == fe_rs2) & (fe_rs2 != '0);
  assign hit_rd = de_valid & de_wr_reg & (de_rd == fe_rd)  & (fe_rd  != '0);
  assign pend1   = pend_of(cnt_arr[fe_rs1], hit1);
  assign pend2   = pend_of(cnt_arr[fe_rs2], hit2);
  assign pend_rd = pend_of(cnt_arr[fe_rd], hit_rd);

`ifdef DE_WB_BYPASS_EN
  // Only the last outstanding write may be forwarded, otherwise an older value would leak.
  assign byp1 = wb_valid & (wb_rd == fe_rs1) & (pend1 == (CNT_W+1)'(1)) & (cnt_arr[fe_rs1] == sb_cnt_t'(1));
  assign byp2 = wb_valid & (wb_rd == fe_rs2) & (pend2 == (CNT_W+1)'(1)) & (cnt_arr[fe_rs2] == sb_cnt_t'(1));
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign src_haz1 = fe_rs1_rd & (pend1 != '0) & ~byp1;
  assign src_haz2 = fe_rs2_rd & (pend2 != '0) & ~byp2;
  assign waw_haz  = fe_wr_reg & (max_vec[fe_rd] | (pend_rd == (CNT_W+1)'(CNT_MAX)));

  assign fe_ready = ~flush & ~src_haz1 & ~src_haz2 & ~waw_haz & (~de_valid | de_ready);
  assign fe_fire  = fe_valid & fe_ready;
  assign de_fire  = de_valid & de_ready & ~flush;

  assign rs1_op = (fe_rs1 == '0) ? '0 : (byp1 ? wb_data : regs[fe_rs1]);
  assign rs2_op = (fe_rs2 == '0) ? '0 : (byp2 ? wb_data : regs[fe_rs2]);

  assign busy = ~&zero_vec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_valid && wb_rd != '0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_valid   <= 1'b0;
      de_rs1_val <= '0;
      de_rs2_val <= '0;
      de_rd      <= '0;
      de_wr_reg  <= 1'b0;
      de_payload <= '0;
    end else if (fe_fire) begin
      de_valid   <= 1'b1;
      de_rs1_val <= rs1_op;
      de_rs2_val <= rs2_op;
      de_rd      <= fe_rd;
      de_wr_reg  <= fe_wr_reg;
      de_payload <= fe_payload;
    end else if (de_fire || flush) begin
      de_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_err <= 1'b0;
    end else if (|uf_vec) begin
      sb_err <= 1'b1;
    end
  end

endmodule
